// File: rtl/pupil_locator.sv
// pupil_locator: thresholds the gray pixel stream inside an ROI, accumulates dark-pixel
// count and coordinate sums per frame, and reports the centroid as a BOX-sized marker origin.
module pupil_locator #(
    parameter int CNTW    = 22,
    parameter int SUMW    = 35,
    parameter int BOX     = 40,
    parameter int ROI_X0  = 16,
    parameter int ROI_X1  = 1264,
    parameter int ROI_Y0  = 16,
    parameter int ROI_Y1  = 944,
    parameter int MIN_PIX = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    input  logic [9:0]  iGRAY,
    input  logic [12:0] iH_Cont,
    input  logic [12:0] iV_Cont,
    input  logic [9:0]  iTHRESH,
    output logic [15:0] oPosX,
    output logic [15:0] oPosY,
    output logic        oFound,
    output logic        oValid,
    output logic        oOverrun
);
    localparam int IW = $clog2(SUMW);

    typedef enum logic [2:0] {IDLE, CHECK, DIVX, DIVY, UPDATE} state_t;

    state_t          state_q, state_d;
    logic [12:0]     vlast_q, quo_n, qx_q, qy_q;
    logic [11:0]     quo_q;
    logic [CNTW-1:0] cnt_q, cnt_d, snap_cnt_q, rem_q, rem_n;
    logic [SUMW-1:0] sx_q, sx_d, sy_q, sy_d, snap_sx_q, snap_sy_q;
    logic [IW-1:0]   idx_q;
    logic [CNTW:0]   rem_sh;
    logic            boundary, hit, ge, last, found_q, upd_q;

    assign boundary = iDVAL && (iV_Cont < vlast_q);
    assign hit      = iDVAL && (iGRAY < iTHRESH)
                      && (iH_Cont >= 13'(ROI_X0)) && (iH_Cont <= 13'(ROI_X1))
                      && (iV_Cont >= 13'(ROI_Y0)) && (iV_Cont <= 13'(ROI_Y1));

    // The boundary pixel lands in a freshly cleared set; a saturated count freezes the sums.
    always_comb begin
        cnt_d = boundary ? '0 : cnt_q;
        sx_d  = boundary ? '0 : sx_q;
        sy_d  = boundary ? '0 : sy_q;
        if (hit && !(&cnt_d)) begin
            cnt_d = cnt_d + CNTW'(1);
            sx_d  = sx_d + SUMW'(iH_Cont);
            sy_d  = sy_d + SUMW'(iV_Cont);
        end
    end

    assign rem_sh = {rem_q, (state_q == DIVX) ? snap_sx_q[SUMW-1] : snap_sy_q[SUMW-1]};
    assign ge     = rem_sh >= {1'b0, snap_cnt_q};
    assign rem_n  = ge ? CNTW'(rem_sh - {1'b0, snap_cnt_q}) : rem_sh[CNTW-1:0];
    assign quo_n  = {quo_q, ge};
    assign last   = idx_q == IW'(SUMW - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = boundary ? CHECK : IDLE;
            CHECK:   state_d = (snap_cnt_q < CNTW'(MIN_PIX)) ? UPDATE : DIVX;
            DIVX:    state_d = last ? DIVY : DIVX;
            DIVY:    state_d = last ? UPDATE : DIVY;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q    <= IDLE;
            vlast_q    <= '0;
            cnt_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            snap_cnt_q <= '0;
            snap_sx_q  <= '0;
            snap_sy_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            idx_q      <= '0;
            qx_q       <= '0;
            qy_q       <= '0;
            found_q    <= 1'b0;
            upd_q      <= 1'b0;
            oPosX      <= '0;
            oPosY      <= '0;
            oFound     <= 1'b0;
            oValid     <= 1'b0;
            oOverrun   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            if (iDVAL)
                vlast_q <= iV_Cont;
            if (boundary && state_q == IDLE) begin
                snap_cnt_q <= cnt_q;
                snap_sx_q  <= sx_q;
                snap_sy_q  <= sy_q;
            end
            if (boundary && state_q != IDLE)
                oOverrun <= 1'b1;
            if (state_q == CHECK)
                found_q <= snap_cnt_q >= CNTW'(MIN_PIX);
            // Divider state returns to zero on the last step, ready for the next pass.
            if (state_q == DIVX || state_q == DIVY) begin
                rem_q <= last ? '0 : rem_n;
                quo_q <= last ? '0 : quo_n[11:0];
                idx_q <= last ? '0 : idx_q + IW'(1);
            end
            if (state_q == DIVX) begin
                snap_sx_q <= snap_sx_q << 1;
                if (last)
                    qx_q <= quo_n;
            end
            if (state_q == DIVY) begin
                snap_sy_q <= snap_sy_q << 1;
                if (last)
                    qy_q <= quo_n;
            end
            upd_q  <= state_q == UPDATE;
            oValid <= upd_q;
            if (upd_q) begin
                oFound <= found_q;
                if (found_q) begin
                    oPosX <= (qx_q >= 13'(BOX / 2)) ? 16'(qx_q - 13'(BOX / 2)) : '0;
                    oPosY <= (qy_q >= 13'(BOX / 2)) ? 16'(qy_q - 13'(BOX / 2)) : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pupil_locator.sv
// tb_pupil_locator: sparse synthetic frames checked against a pixel-list centroid model.
module tb_pupil_locator;
    logic        iCLK = 1'b0, iRST = 1'b0, iDVAL = 1'b0;
    logic [9:0]  iGRAY = '0, iTHRESH = 10'd100;
    logic [12:0] iH_Cont = '0, iV_Cont = '0;
    logic [15:0] oPosX, oPosY, zPosX, zPosY;
    logic        oFound, oValid, oOverrun, zFound, zValid, zOverrun;
    int          checks = 0, errors = 0;

    pupil_locator dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iGRAY(iGRAY), .iH_Cont(iH_Cont),
        .iV_Cont(iV_Cont), .iTHRESH(iTHRESH), .oPosX(oPosX), .oPosY(oPosY),
        .oFound(oFound), .oValid(oValid), .oOverrun(oOverrun)
    );

    pupil_locator #(.ROI_X0(0), .ROI_Y0(0)) dut_z (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iGRAY(iGRAY), .iH_Cont(iH_Cont),
        .iV_Cont(iV_Cont), .iTHRESH(iTHRESH), .oPosX(zPosX), .oPosY(zPosY),
        .oFound(zFound), .oValid(zValid), .oOverrun(zOverrun)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {int h; int v; bit dark;} pix_t;
    pix_t frame_q[$];
    pix_t last_frame[$];
    int   m_vlast = 0, m_ex = 0, m_ey = 0, m_lat = 0;
    bit   m_ef = 0;

    function automatic void m_reset();
        frame_q.delete();
        last_frame.delete();
        m_vlast = 0;
        m_ex = 0;
        m_ey = 0;
        m_ef = 0;
    endfunction

    function automatic void m_pix(input int g, input int h, input int v, input int th);
        if (v < m_vlast) begin
            last_frame = frame_q;
            frame_q.delete();
        end
        frame_q.push_back('{h, v, g < th});
        m_vlast = v;
    endfunction

    // Centroid of the just-closed frame for a given ROI origin.
    function automatic void eval(input int x0, input int y0, output bit f, output int px, output int py);
        longint cnt = 0, sx = 0, sy = 0;
        foreach (last_frame[i])
            if (last_frame[i].dark && last_frame[i].h >= x0 && last_frame[i].h <= 1264 &&
                last_frame[i].v >= y0 && last_frame[i].v <= 944) begin
                cnt++;
                sx += last_frame[i].h;
                sy += last_frame[i].v;
            end
        f  = cnt >= 64;
        px = 0;
        py = 0;
        if (f) begin
            px = int'(sx / cnt) - 20;
            py = int'(sy / cnt) - 20;
            if (px < 0) px = 0;
            if (py < 0) py = 0;
        end
    endfunction

    function automatic void commit();
        bit f;
        int x, y;
        eval(16, 16, f, x, y);
        m_ef  = f;
        m_lat = f ? 73 : 3;
        if (f) begin
            m_ex = x;
            m_ey = y;
        end
    endfunction

    task automatic drive(input int g, input int h, input int v, input int th);
        iDVAL = 1'b1;
        iGRAY = 10'(g);
        iH_Cont = 13'(h);
        iV_Cont = 13'(v);
        iTHRESH = 10'(th);
        m_pix(g, h, v, th);
        @(negedge iCLK);
        iDVAL = 1'b0;
    endtask

    task automatic send_block(input int bx, input int by, input int w, input int hh, input int g, input int th);
        for (int r = 0; r < hh; r++) begin
            for (int c = 0; c < w; c++)
                drive(g, bx + c, by + r, th);
            if ($urandom_range(0, 1) == 1)
                drive(500 + int'($urandom_range(0, 500)), int'($urandom_range(0, 1279)), by + r, th);
        end
    endtask

    task automatic wrap(input int th);
        drive(900, 0, 0, th);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic wait_valid(input bit z, output int lat, output bit dbl);
        lat = -1;
        dbl = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge iCLK);
            if (z ? zValid : oValid) begin
                lat = n;
                @(negedge iCLK);
                dbl = z ? zValid : oValid;
                break;
            end
        end
    endtask

    task automatic test_reset;
        iRST = 1'b0;
        idle(3);
        if ({oPosX, oPosY} !== 32'd0) begin errors++; $display("FAIL reset_pos: got %0d,%0d expected 0,0", oPosX, oPosY); end
        checks++;
        if ({oFound, oValid, oOverrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {oFound, oValid, oOverrun}); end
        checks++;
        iRST = 1'b1;
        m_reset();
        idle(3);
    endtask

    task automatic check_result(input string name, input int lat, input bit dbl);
        // Reports any disagreement between the DUT and the model's last delivered frame.
        if (lat !== m_lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, m_lat); end
        checks++;
        if (oPosX !== 16'(m_ex) || oPosY !== 16'(m_ey)) begin errors++; $display("FAIL %s_pos: got %0d,%0d expected %0d,%0d", name, oPosX, oPosY, m_ex, m_ey); end
        checks++;
        if (oFound !== m_ef) begin errors++; $display("FAIL %s_found: got %b expected %b", name, oFound, m_ef); end
        checks++;
        if (dbl !== 1'b0) begin errors++; $display("FAIL %s_pulse: oValid high two cycles, got %b expected 0", name, dbl); end
        checks++;
    endtask

    task automatic test_found;
        int lat;
        bit dbl;
        send_block(200, 300, 8, 8, 50, 100);
        wrap(100);
        commit();
        wait_valid(0, lat, dbl);
        check_result("frame1", lat, dbl);
        if (oPosX !== 16'd183 || oPosY !== 16'd283) begin errors++; $display("FAIL frame1_abs: got %0d,%0d expected 183,283", oPosX, oPosY); end
        checks++;
        if (oOverrun !== 1'b0) begin errors++; $display("FAIL frame1_overrun: got %b expected 0", oOverrun); end
        checks++;
        idle(80);
    endtask

    task automatic test_roi_outside;
        int lat;
        bit dbl;
        for (int i = 0; i < 70; i++)
            drive(40, 10, 300 + i, 100);
        wrap(100);
        commit();
        wait_valid(0, lat, dbl);
        check_result("roi_outside", lat, dbl);
        idle(80);
    endtask

    task automatic test_reset_mid_divy;
        int lat, seen;
        bit dbl;
        seen = 0;
        send_block(int'($urandom_range(16, 1200)), int'($urandom_range(16, 880)), 8, 8, 20, 100);
        wrap(100);
        for (int n = 0; n < 50; n++) begin
            @(negedge iCLK);
            if (oValid) seen++;
        end
        iRST = 1'b0;
        #1;
        if ({oPosX, oPosY, oFound, oValid, oOverrun} !== 35'd0) begin errors++; $display("FAIL mid_reset_outputs: got %0d,%0d,%b%b%b expected all 0", oPosX, oPosY, oFound, oValid, oOverrun); end
        checks++;
        @(negedge iCLK);
        iRST = 1'b1;
        m_reset();
        for (int n = 0; n < 100; n++) begin
            @(negedge iCLK);
            if (oValid) seen++;
        end
        if (seen !== 0) begin errors++; $display("FAIL mid_reset_valid: got %0d pulses expected 0", seen); end
        checks++;
        if ({oPosX, oPosY, oFound} !== 33'd0) begin errors++; $display("FAIL mid_reset_hold: got %0d,%0d,%b expected 0,0,0", oPosX, oPosY, oFound); end
        checks++;
        send_block(int'($urandom_range(16, 1200)), int'($urandom_range(16, 880)), 8, 8, 20, 100);
        wrap(100);
        commit();
        wait_valid(0, lat, dbl);
        check_result("after_reset", lat, dbl);
        idle(80);
    endtask

    task automatic test_thresh_edge;
        int lat;
        bit dbl;
        send_block(int'($urandom_range(16, 1200)), int'($urandom_range(16, 880)), 8, 8, 100, 100);
        wrap(100);
        commit();
        wait_valid(0, lat, dbl);
        check_result("gray_eq_thresh", lat, dbl);
        idle(80);
        send_block(int'($urandom_range(16, 1200)), int'($urandom_range(16, 880)), 9, 7, 99, 100);
        wrap(100);
        commit();
        wait_valid(0, lat, dbl);
        check_result("min_pix_63", lat, dbl);
        idle(80);
        send_block(int'($urandom_range(16, 1200)), int'($urandom_range(16, 880)), 8, 8, 99, 100);
        wrap(100);
        commit();
        wait_valid(0, lat, dbl);
        check_result("min_pix_64", lat, dbl);
        idle(80);
    endtask

    task automatic test_clamp;
        int lat, zx, zy;
        bit dbl, zf;
        send_block(8, 8, 9, 9, 30, 100);
        wrap(100);
        commit();
        eval(0, 0, zf, zx, zy);
        wait_valid(1, lat, dbl);
        if (lat !== 73) begin errors++; $display("FAIL clamp_latency: got %0d expected 73", lat); end
        checks++;
        if (zPosX !== 16'(zx) || zPosY !== 16'(zy) || zFound !== zf) begin errors++; $display("FAIL clamp_pos: got %0d,%0d,%b expected %0d,%0d,%b", zPosX, zPosY, zFound, zx, zy, zf); end
        checks++;
        if (oFound !== m_ef || oPosX !== 16'(m_ex) || oPosY !== 16'(m_ey)) begin errors++; $display("FAIL clamp_default: got %0d,%0d,%b expected %0d,%0d,%b", oPosX, oPosY, oFound, m_ex, m_ey, m_ef); end
        checks++;
        idle(80);
    endtask

    task automatic test_random;
        int lat, by, hh, th, g;
        bit dbl;
        for (int k = 0; k < 6; k++) begin
            by = int'($urandom_range(16, 880));
            hh = int'($urandom_range(4, 12));
            th = int'($urandom_range(60, 400));
            g  = int'($urandom_range(0, th - 1));
            send_block(int'($urandom_range(16, 1200)), by, int'($urandom_range(4, 12)), hh, g, th);
            drive(g, int'($urandom_range(0, 15)), by + hh, th);
            drive(g, int'($urandom_range(1265, 1279)), by + hh, th);
            wrap(th);
            commit();
            wait_valid(0, lat, dbl);
            check_result("random", lat, dbl);
            idle(80);
        end
    endtask

    task automatic test_overrun;
        int lat;
        bit dbl, prev, ov19;
        lat = -1;
        dbl = 0;
        prev = 0;
        ov19 = 1;
        send_block(int'($urandom_range(16, 1200)), int'($urandom_range(16, 880)), 8, 8, 20, 100);
        wrap(100);
        commit();
        for (int n = 1; n <= 100; n++) begin
            iDVAL   = (n == 1 || n == 20);
            iGRAY   = 10'd900;
            iH_Cont = 13'd600;
            iV_Cont = (n == 1) ? 13'd500 : 13'd0;
            iTHRESH = 10'd100;
            if (iDVAL) m_pix(900, 600, int'(iV_Cont), 100);
            @(negedge iCLK);
            if (n == 19) ov19 = oOverrun;
            if (oValid && lat < 0) lat = n;
            if (oValid && prev) dbl = 1;
            prev = oValid;
        end
        iDVAL = 1'b0;
        if (ov19 !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b expected 0", ov19); end
        checks++;
        if (oOverrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", oOverrun); end
        checks++;
        check_result("overrun_first", lat, dbl);
        idle(80);
        if (oOverrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", oOverrun); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_found();
        test_roi_outside();
        test_reset_mid_divy();
        test_thresh_edge();
        test_clamp();
        test_random();
        test_overrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
